// File: rtl/joystick_direction_filter_if.sv
// ---------------------------------------------------------------------------
// joystick_direction_filter_if
// Bundles the stick position inputs and the filtered direction outputs of
// joystick_direction_filter.
//   positionX  [7:0] horizontal stick position, larger than centre = right
//   positionY  [7:0] vertical stick position, larger than centre = up
//   dir        [1:0] committed direction: 0 up, 1 right, 2 down, 3 left
//   dir_valid        a direction has been committed since reset
//   dir_change       one-cycle pulse when dir takes a new value
//   active           latest committed classification is non-neutral
// Modports: master = position source / direction consumer, slave = filter.
// ---------------------------------------------------------------------------
interface joystick_direction_filter_if;
  logic [7:0] positionX;
  logic [7:0] positionY;
  logic [1:0] dir;
  logic       dir_valid;
  logic       dir_change;
  logic       active;

  modport master (
    output positionX,
    output positionY,
    input  dir,
    input  dir_valid,
    input  dir_change,
    input  active
  );

  modport slave (
    input  positionX,
    input  positionY,
    output dir,
    output dir_valid,
    output dir_change,
    output active
  );
endinterface

// File: rtl/joystick_direction_filter.sv
// ---------------------------------------------------------------------------
// joystick_direction_filter
// Turns the 8-bit X/Y stick positions into a debounced 4-way movement
// command. Positions are captured every SAMPLE_DIV clocks, classified with a
// centre dead zone and dominant-axis selection, and a classification is only
// committed after STABLE_COUNT consecutive identical samples.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    joystick_direction_filter_if.slave (positions in, direction out)
// ---------------------------------------------------------------------------
module joystick_direction_filter #(
  parameter int SAMPLE_DIV   = 50000,
  parameter int CENTER       = 128,
  parameter int DEADZONE     = 40,
  parameter int STABLE_COUNT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  joystick_direction_filter_if.slave    bus
);

  localparam int                CNT_W      = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [7:0]        CENTER_8   = 8'(CENTER);
  localparam logic [8:0]        DEADZONE_9 = 9'(DEADZONE);
  localparam logic [3:0]        STABLE_4   = 4'(STABLE_COUNT);

  // Classification: bit 2 set = neutral, otherwise bits 1:0 hold the direction.
  localparam logic [2:0] CLS_UP      = 3'b000;
  localparam logic [2:0] CLS_RIGHT   = 3'b001;
  localparam logic [2:0] CLS_DOWN    = 3'b010;
  localparam logic [2:0] CLS_LEFT    = 3'b011;
  localparam logic [2:0] CLS_NEUTRAL = 3'b100;

  // Magnitude of a 9-bit two's complement offset; -128 maps to 128 without overflow.
  function automatic logic [8:0] abs9(input logic [8:0] v);
    abs9 = v[8] ? (~v + 9'd1) : v;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       x_q, y_q;
  logic             en_q;
  logic [2:0]       cand_q, cand_d;
  logic [3:0]       stab_q, stab_d;
  logic [1:0]       dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             change_q, change_d;
  logic             active_q, active_d;

  logic             tick_s;
  logic [8:0]       dx_s, dy_s, ax_s, ay_s;
  logic [2:0]       raw_s;

  assign tick_s = (cnt_q == CNT_LAST);

  // Sample-rate divider: free-running 0..SAMPLE_DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_s) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Classify the captured sample: dead zone first, then dominant axis (tie -> horizontal).
  always_comb begin
    dx_s  = {1'b0, x_q} - {1'b0, CENTER_8};
    dy_s  = {1'b0, y_q} - {1'b0, CENTER_8};
    ax_s  = abs9(dx_s);
    ay_s  = abs9(dy_s);
    raw_s = CLS_NEUTRAL;
    if ((ax_s <= DEADZONE_9) && (ay_s <= DEADZONE_9)) begin
      raw_s = CLS_NEUTRAL;
    end else if (ax_s >= ay_s) begin
      // Sign bit clear and non-zero means strictly positive offset.
      if (!dx_s[8] && (dx_s != 9'd0)) begin
        raw_s = CLS_RIGHT;
      end else begin
        raw_s = CLS_LEFT;
      end
    end else begin
      if (!dy_s[8] && (dy_s != 9'd0)) begin
        raw_s = CLS_UP;
      end else begin
        raw_s = CLS_DOWN;
      end
    end
  end

  // Candidate tracking, stability counting and commit decision.
  always_comb begin
    cand_d   = cand_q;
    stab_d   = stab_q;
    dir_d    = dir_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    active_d = active_q;
    if (en_q) begin
      if (raw_s == cand_q) begin
        if (stab_q >= STABLE_4) begin
          stab_d = STABLE_4;
        end else begin
          stab_d = stab_q + 4'd1;
        end
      end else begin
        cand_d = raw_s;
        stab_d = 4'd1;
      end
      // Commit on the edge where the updated count reaches the threshold.
      if (stab_d == STABLE_4) begin
        if (cand_d[2]) begin
          // Neutral keeps the last heading; only the activity flag drops.
          active_d = 1'b0;
        end else begin
          active_d = 1'b1;
          if (!valid_q || (cand_d[1:0] != dir_q)) begin
            dir_d    = cand_d[1:0];
            valid_d  = 1'b1;
            change_d = 1'b1;
          end else begin
            dir_d    = dir_q;
          end
        end
      end else begin
        active_d = active_q;
      end
    end else begin
      cand_d = cand_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= CNT_ZERO;
      x_q      <= CENTER_8;
      y_q      <= CENTER_8;
      en_q     <= 1'b0;
      cand_q   <= CLS_NEUTRAL;
      stab_q   <= 4'd0;
      dir_q    <= 2'd0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      if (tick_s) begin
        x_q <= bus.positionX;
        y_q <= bus.positionY;
      end
      en_q     <= tick_s;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      dir_q    <= dir_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      active_q <= active_d;
    end
  end

  assign bus.dir        = dir_q;
  assign bus.dir_valid  = valid_q;
  assign bus.dir_change = change_q;
  assign bus.active     = active_q;

endmodule

// File: tb/tb_joystick_direction_filter.sv
// ---------------------------------------------------------------------------
// tb_joystick_direction_filter
// Directed bench for joystick_direction_filter with SAMPLE_DIV=4,
// STABLE_COUNT=3, DEADZONE=40, CENTER=128. Inputs change on falling edges
// right after a capture edge, so every 4 cycles later exactly one new sample
// has been taken.
// ---------------------------------------------------------------------------
module tb_joystick_direction_filter;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   pulses       = 0;
  int   consec       = 0;
  int   base;
  logic prev_chg     = 1'b0;

  joystick_direction_filter_if bus ();

  joystick_direction_filter #(
    .SAMPLE_DIV  (4),
    .CENTER      (128),
    .DEADZONE    (40),
    .STABLE_COUNT(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Count dir_change pulses and any back-to-back pulses.
  always @(posedge clk) begin
    if (bus.dir_change === 1'b1) begin
      pulses <= pulses + 1;
      if (prev_chg) consec <= consec + 1;
    end
    prev_chg <= (bus.dir_change === 1'b1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // 1. Reset with stick hard right.
    reset = 1'b1;
    bus.positionX = 8'd255;
    bus.positionY = 8'd128;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_dir",    32'(bus.dir),        32'd0);
      check_eq("rst_valid",  32'(bus.dir_valid),  32'd0);
      check_eq("rst_change", 32'(bus.dir_change), 32'd0);
      check_eq("rst_active", 32'(bus.active),     32'd0);
    end
    reset = 1'b0;
    base  = pulses;

    // 2. Right commits after the third sample, pulse exactly 13 cycles after release.
    cycles(12);
    check_eq("pre_valid",  32'(bus.dir_valid),  32'd0);
    check_eq("pre_change", 32'(bus.dir_change), 32'd0);
    cycles(1);
    check_eq("r_change",   32'(bus.dir_change), 32'd1);
    check_eq("r_dir",      32'(bus.dir),        32'd1);
    check_eq("r_valid",    32'(bus.dir_valid),  32'd1);
    check_eq("r_active",   32'(bus.active),     32'd1);
    cycles(1);
    check_eq("r_pulse_end", 32'(bus.dir_change), 32'd0);
    cycles(2);
    check_eq("r_pulses", 32'(pulses - base), 32'd1);
    base = pulses;
    cycles(40);
    check_eq("hold_pulses", 32'(pulses - base), 32'd0);
    check_eq("hold_dir",    32'(bus.dir),       32'd1);

    // 3. Inside the dead zone: active drops, heading kept.
    bus.positionX = 8'd160;
    bus.positionY = 8'd100;
    base = pulses;
    cycles(16);
    check_eq("dz_active", 32'(bus.active),     32'd0);
    check_eq("dz_dir",    32'(bus.dir),        32'd1);
    check_eq("dz_valid",  32'(bus.dir_valid),  32'd1);
    check_eq("dz_pulses", 32'(pulses - base),  32'd0);

    // 4. Short left glitch is filtered; then down commits.
    bus.positionX = 8'd0;
    bus.positionY = 8'd128;
    cycles(8);
    bus.positionX = 8'd255;
    base = pulses;
    cycles(16);
    check_eq("glitch_dir",    32'(bus.dir),       32'd1);
    check_eq("glitch_active", 32'(bus.active),    32'd1);
    check_eq("glitch_pulses", 32'(pulses - base), 32'd0);
    bus.positionX = 8'd128;
    bus.positionY = 8'd0;
    base = pulses;
    cycles(16);
    check_eq("down_dir",    32'(bus.dir),       32'd2);
    check_eq("down_pulses", 32'(pulses - base), 32'd1);
    check_eq("down_active", 32'(bus.active),    32'd1);

    // 5. Tie goes horizontal; then up.
    bus.positionX = 8'd200;
    bus.positionY = 8'd56;
    base = pulses;
    cycles(16);
    check_eq("tie_dir",    32'(bus.dir),       32'd1);
    check_eq("tie_pulses", 32'(pulses - base), 32'd1);
    bus.positionX = 8'd128;
    bus.positionY = 8'd255;
    base = pulses;
    cycles(16);
    check_eq("up_dir",    32'(bus.dir),       32'd0);
    check_eq("up_pulses", 32'(pulses - base), 32'd1);

    // 6. Reset mid-count discards progress toward left.
    bus.positionX = 8'd0;
    bus.positionY = 8'd128;
    cycles(8);
    reset = 1'b1;
    cycles(1);
    check_eq("mrst_dir",    32'(bus.dir),       32'd0);
    check_eq("mrst_valid",  32'(bus.dir_valid), 32'd0);
    check_eq("mrst_active", 32'(bus.active),    32'd0);
    reset = 1'b0;
    base  = pulses;
    cycles(12);
    check_eq("l_pre_valid",  32'(bus.dir_valid),  32'd0);
    check_eq("l_pre_change", 32'(bus.dir_change), 32'd0);
    check_eq("l_pre_pulses", 32'(pulses - base),  32'd0);
    cycles(1);
    check_eq("l_change", 32'(bus.dir_change), 32'd1);
    check_eq("l_dir",    32'(bus.dir),        32'd3);
    check_eq("l_valid",  32'(bus.dir_valid),  32'd1);
    cycles(3);
    check_eq("l_pulses", 32'(pulses - base), 32'd1);
    check_eq("no_consecutive_pulses", 32'(consec), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
